// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl: rock-paper-scissors round sequencer; counters the player's most frequent throw,
// drives the two-image display handshake, then scores the round with saturating digits.
module rps_round_ctrl #(
   parameter int HIST_W = 4,
   parameter int SCORE_MAX = 9
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       go,
   input  logic [1:0] user_choice,
   input  logic       clr,
   input  logic       draw_done,
   output logic       draw_start,
   output logic       draw_player,
   output logic [1:0] draw_choice,
   output logic [1:0] comp_choice,
   output logic [2:0] result,
   output logic [3:0] user_score,
   output logic [3:0] comp_score,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, DECIDE, DRAW_U, WAIT_U, DRAW_C, WAIT_C, SCORE} state_t;
   localparam logic [HIST_W-1:0] H_MAX = '1;
   state_t state;
   logic [HIST_W-1:0] h_r, h_s, h_p, h_sel;
   logic [1:0] u_reg, most, counter;
   logic sat, u_win, c_win;
   always_comb begin
      most = (h_r >= h_s && h_r >= h_p) ? 2'b00 : (h_s >= h_p) ? 2'b01 : 2'b10;
      counter = most == 2'b00 ? 2'b10 : most == 2'b01 ? 2'b00 : 2'b01;
      h_sel = u_reg == 2'b00 ? h_r : u_reg == 2'b01 ? h_s : h_p;
      sat = h_sel == H_MAX;
      u_win = (u_reg == 2'b00 && comp_choice == 2'b01) || (u_reg == 2'b01 && comp_choice == 2'b10) ||
              (u_reg == 2'b10 && comp_choice == 2'b00);
      c_win = u_reg != comp_choice && !u_win;
   end
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         h_r <= '0;
         h_s <= '0;
         h_p <= '0;
         u_reg <= 2'b00;
         draw_start <= 1'b0;
         draw_player <= 1'b0;
         draw_choice <= 2'b00;
         comp_choice <= 2'b00;
         result <= 3'b000;
         user_score <= 4'd0;
         comp_score <= 4'd0;
         busy <= 1'b0;
      end else begin
         draw_start <= 1'b0;
         case (state)
            IDLE:
               if (clr) begin
                  h_r <= '0;
                  h_s <= '0;
                  h_p <= '0;
                  result <= 3'b000;
                  user_score <= 4'd0;
                  comp_score <= 4'd0;
               end else if (go && user_choice != 2'b11) begin
                  u_reg <= user_choice;
                  busy <= 1'b1;
                  state <= DECIDE;
               end
            DECIDE: begin
               comp_choice <= counter;
               result <= 3'b000;
               // a full counter halves the whole history so relative frequencies survive
               h_r <= (sat ? h_r >> 1 : h_r) + HIST_W'(u_reg == 2'b00);
               h_s <= (sat ? h_s >> 1 : h_s) + HIST_W'(u_reg == 2'b01);
               h_p <= (sat ? h_p >> 1 : h_p) + HIST_W'(u_reg == 2'b10);
               draw_start <= 1'b1;
               draw_player <= 1'b0;
               draw_choice <= u_reg;
               state <= DRAW_U;
            end
            DRAW_U: state <= WAIT_U;
            WAIT_U:
               if (draw_done) begin
                  draw_start <= 1'b1;
                  draw_player <= 1'b1;
                  draw_choice <= comp_choice;
                  state <= DRAW_C;
               end
            DRAW_C: state <= WAIT_C;
            WAIT_C: if (draw_done) state <= SCORE;
            SCORE: begin
               result <= {u_reg == comp_choice, c_win, u_win};
               user_score <= user_score + 4'(u_win && user_score < 4'(SCORE_MAX));
               comp_score <= comp_score + 4'(c_win && comp_score < 4'(SCORE_MAX));
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
